// File: rtl/lane_thread_dispatcher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : lane_thread_dispatcher
// Description : Splits an active-mask chunk into per-lane sub-masks by the
//               unrolling interleave and streams each lane's set-bit global
//               indices over independent valid/ready handshakes.
//               Optional counters enabled by macro LANE_DISPATCH_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_thread_dispatcher #(
    parameter int MASK_WIDTH = 256,
    parameter int NUM_LANES  = 4,
    parameter int LANE_WIDTH = MASK_WIDTH / NUM_LANES,
    parameter int IDX_W      = $clog2(MASK_WIDTH),
    parameter int U_W        = $clog2($clog2(NUM_LANES) + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_valid,
    output logic                       start_ready,
    input  logic [MASK_WIDTH-1:0]      start_mask,
    input  logic [U_W-1:0]             start_unroll,
    output logic [NUM_LANES-1:0]       lane_valid,
    input  logic [NUM_LANES-1:0]       lane_ready,
    output logic [NUM_LANES*IDX_W-1:0] lane_index,
    output logic                       busy,
    output logic                       done,
`ifdef LANE_DISPATCH_PERF_EN
    output logic [31:0]                perf_issued,
    output logic [31:0]                perf_stall,
`endif
    output logic                       err
);

    localparam int c_log2_lanes = $clog2(NUM_LANES);
    localparam int c_pos_w      = (LANE_WIDTH > 1) ? $clog2(LANE_WIDTH) : 1;
    localparam logic [LANE_WIDTH-1:0] c_one = LANE_WIDTH'(1);

    localparam logic [1:0] c_st_idle     = 2'd0;
    localparam logic [1:0] c_st_dispatch = 2'd1;
    localparam logic [1:0] c_st_done     = 2'd2;

    function automatic int f_chunk(input int u);
        return (u == 0) ? LANE_WIDTH : (LANE_WIDTH >> (u + 1));
    endfunction

    function automatic bit f_u_valid(input int u);
        return (u <= c_log2_lanes) && (f_chunk(u) >= 1);
    endfunction

    // Global mask index owned by bit p of lane `lane` under unroll log2 u.
    function automatic int f_map(input int u, input int lane, input int p);
        int n_sub;
        int grp;
        int sub;
        int chunk;
        n_sub = 1 << u;
        grp   = lane >> u;
        sub   = lane % n_sub;
        chunk = f_chunk(u);
        return grp * n_sub * LANE_WIDTH + (p / chunk) * n_sub * chunk
               + sub * chunk + (p % chunk);
    endfunction

    logic [1:0]                            r_state;
    logic [1:0]                            w_state_nxt;
    logic [NUM_LANES-1:0][LANE_WIDTH-1:0]  r_mask;
    logic [NUM_LANES-1:0][LANE_WIDTH-1:0]  w_mask_after;
    logic [NUM_LANES-1:0][LANE_WIDTH-1:0]  w_gather;
    logic [NUM_LANES-1:0][c_pos_w-1:0]     w_low_pos;
    logic [NUM_LANES-1:0][IDX_W-1:0]       w_index;
    logic [NUM_LANES-1:0]                  w_hs;
    logic [U_W-1:0]                        r_unroll;
    logic                                  r_err;
    logic                                  w_start_u_ok;
    logic                                  w_accept;

    always_comb begin
        w_gather     = '0;
        w_start_u_ok = 1'b0;
        for (int uu = 0; uu <= c_log2_lanes; uu++) begin
            if (f_u_valid(uu) && (int'(start_unroll) == uu)) begin
                w_start_u_ok = 1'b1;
                for (int l = 0; l < NUM_LANES; l++) begin
                    for (int p = 0; p < LANE_WIDTH; p++) begin
                        w_gather[l][p] = start_mask[IDX_W'(f_map(uu, l, p))];
                    end
                end
            end
        end
    end

    // Lowest set bit per lane and its mapped global index.
    always_comb begin
        w_low_pos = '0;
        w_index   = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            for (int p = LANE_WIDTH - 1; p >= 0; p--) begin
                if (r_mask[l][p]) begin
                    w_low_pos[l] = c_pos_w'(p);
                end
            end
            for (int uu = 0; uu <= c_log2_lanes; uu++) begin
                if (f_u_valid(uu) && (int'(r_unroll) == uu)) begin
                    w_index[l] = IDX_W'(f_map(uu, l, int'(w_low_pos[l])));
                end
            end
        end
    end

    assign w_hs = lane_valid & lane_ready;

    always_comb begin
        w_mask_after = r_mask;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (w_hs[l]) begin
                w_mask_after[l] = r_mask[l] & (r_mask[l] - c_one);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (start_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (w_start_u_ok && (|w_gather)) ? c_st_dispatch : c_st_done;
                end
            end
            c_st_dispatch: begin
                if (w_mask_after == '0) begin
                    w_state_nxt = c_st_done;
                end
            end
            c_st_done: begin
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= c_st_idle;
            r_mask   <= '0;
            r_unroll <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_unroll <= start_unroll;
                r_err    <= !w_start_u_ok;
                r_mask   <= w_start_u_ok ? w_gather : '0;
            end else begin
                r_mask <= w_mask_after;
            end
        end
    end

    for (genvar gl = 0; gl < NUM_LANES; gl++) begin : g_lane
        assign lane_valid[gl]                = (r_state == c_st_dispatch) && (|r_mask[gl]);
        assign lane_index[gl*IDX_W +: IDX_W] = lane_valid[gl] ? w_index[gl] : '0;
    end

    assign start_ready = (r_state == c_st_idle);
    assign busy        = (r_state != c_st_idle);
    assign done        = (r_state == c_st_done);
    assign err         = done && r_err;

`ifdef LANE_DISPATCH_PERF_EN
    localparam int c_cnt_w = $clog2(NUM_LANES + 1);

    logic [31:0]        r_perf_issued;
    logic [31:0]        r_perf_stall;
    logic [c_cnt_w-1:0] w_hs_cnt;
    logic [32:0]        w_issued_sum;

    always_comb begin
        w_hs_cnt = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            w_hs_cnt = w_hs_cnt + c_cnt_w'(w_hs[l]);
        end
        w_issued_sum = {1'b0, r_perf_issued} + 33'(w_hs_cnt);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_issued <= '0;
            r_perf_stall  <= '0;
        end else begin
            r_perf_issued <= w_issued_sum[32] ? '1 : w_issued_sum[31:0];
            if ((|(lane_valid & ~lane_ready)) && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_issued = r_perf_issued;
    assign perf_stall  = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lane_thread_dispatcher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_lane_thread_dispatcher
// Description : Scoreboard bench for lane_thread_dispatcher (default config).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lane_thread_dispatcher;

    localparam int MASK_WIDTH = 256;
    localparam int NUM_LANES  = 4;
    localparam int LANE_WIDTH = 64;
    localparam int IDX_W      = 8;
    localparam int U_W        = 2;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       start_valid;
    logic                       start_ready;
    logic [MASK_WIDTH-1:0]      start_mask;
    logic [U_W-1:0]             start_unroll;
    logic [NUM_LANES-1:0]       lane_valid;
    logic [NUM_LANES-1:0]       lane_ready;
    logic [NUM_LANES*IDX_W-1:0] lane_index;
    logic                       busy;
    logic                       done;
    logic                       err;
`ifdef LANE_DISPATCH_PERF_EN
    logic [31:0]                perf_issued;
    logic [31:0]                perf_stall;
`endif

    int total = 0;
    int bad   = 0;
    int exp_q[NUM_LANES][$];

    always #5 clk = ~clk;

    lane_thread_dispatcher #(
        .MASK_WIDTH (MASK_WIDTH),
        .NUM_LANES  (NUM_LANES)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .start_mask   (start_mask),
        .start_unroll (start_unroll),
        .lane_valid   (lane_valid),
        .lane_ready   (lane_ready),
        .lane_index   (lane_index),
        .busy         (busy),
        .done         (done),
`ifdef LANE_DISPATCH_PERF_EN
        .perf_issued  (perf_issued),
        .perf_stall   (perf_stall),
`endif
        .err          (err)
    );

    // Reference interleave: g = L>>u, s = L mod U, CHUNK from u.
    function automatic int tb_map(input int u, input int l, input int p);
        int n_sub;
        int chunk;
        n_sub = 1 << u;
        chunk = (u == 0) ? LANE_WIDTH : (LANE_WIDTH >> (u + 1));
        return (l >> u) * n_sub * LANE_WIDTH + (p / chunk) * n_sub * chunk
               + (l % n_sub) * chunk + (p % chunk);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_expected(input logic [MASK_WIDTH-1:0] mask, input int u);
        for (int l = 0; l < NUM_LANES; l++) begin
            exp_q[l].delete();
            if (u <= 2) begin
                for (int p = 0; p < LANE_WIDTH; p++) begin
                    if (mask[tb_map(u, l, p)]) exp_q[l].push_back(tb_map(u, l, p));
                end
            end
        end
    endtask

    task automatic accept(input logic [MASK_WIDTH-1:0] mask, input int u);
        total++;
        if (start_ready !== 1'b1) begin
            bad++;
            $display("FAIL accept_ready: start_ready=%b required=1", start_ready);
        end
        start_valid  = 1'b1;
        start_mask   = mask;
        start_unroll = U_W'(u);
        load_expected(mask, u);
        step();
        start_valid  = 1'b0;
        start_mask   = '0;
        start_unroll = '0;
    endtask

    // Runs from T+1 until done, scoring every lane each cycle.
    task automatic drain(input int stall, input bit rand_ready, input bit exp_err,
                         output int cycles);
        logic [IDX_W-1:0] held[NUM_LANES];
        bit               stalled[NUM_LANES];
        logic [IDX_W-1:0] idx;
        bit               finished;
        finished = 1'b0;
        cycles   = -1;
        for (int l = 0; l < NUM_LANES; l++) begin
            stalled[l] = 1'b0;
            held[l]    = '0;
        end
        for (int c = 0; c < 2000 && !finished; c++) begin
            if (c < stall)       lane_ready = '0;
            else if (rand_ready) lane_ready = NUM_LANES'($urandom_range(0, 15));
            else                 lane_ready = '1;
            if (done === 1'b1) begin
                finished = 1'b1;
                cycles   = c + 1;
                total++;
                if (err !== exp_err) begin
                    bad++;
                    $display("FAIL done_err: err=%b required=%b", err, exp_err);
                end
                total++;
                if (lane_valid !== '0) begin
                    bad++;
                    $display("FAIL done_valid: lane_valid=%b required=0", lane_valid);
                end
                for (int l = 0; l < NUM_LANES; l++) begin
                    total++;
                    if (exp_q[l].size() != 0) begin
                        bad++;
                        $display("FAIL done_pending: lane %0d left=%0d required=0", l, exp_q[l].size());
                    end
                end
            end else begin
                total++;
                if (busy !== 1'b1) begin
                    bad++;
                    $display("FAIL busy: busy=%b required=1 cycle=%0d", busy, c);
                end
                for (int l = 0; l < NUM_LANES; l++) begin
                    total++;
                    if (lane_valid[l] !== (exp_q[l].size() != 0)) begin
                        bad++;
                        $display("FAIL lane_valid: lane %0d valid=%b required=%0d cycle=%0d",
                                 l, lane_valid[l], exp_q[l].size() != 0, c);
                    end
                    if (lane_valid[l] === 1'b1) begin
                        idx = lane_index[l*IDX_W +: IDX_W];
                        if (stalled[l]) begin
                            total++;
                            if (idx !== held[l]) begin
                                bad++;
                                $display("FAIL hold: lane %0d index=%0d required=%0d", l, idx, held[l]);
                            end
                        end
                        if (exp_q[l].size() != 0) begin
                            total++;
                            if (idx !== IDX_W'(exp_q[l][0])) begin
                                bad++;
                                $display("FAIL index: lane %0d index=%0d required=%0d", l, idx, exp_q[l][0]);
                            end
                            if (lane_ready[l]) void'(exp_q[l].pop_front());
                        end
                        stalled[l] = !lane_ready[l];
                        held[l]    = idx;
                    end else begin
                        stalled[l] = 1'b0;
                    end
                end
            end
            step();
        end
        lane_ready = '0;
        if (!finished) begin
            total++;
            bad++;
            $display("FAIL timeout: done not seen within 2000 cycles");
        end
        total++;
        if (start_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL after_done: ready=%b done=%b busy=%b required 1 0 0",
                     start_ready, done, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        total++;
        if (start_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: ready=%b busy=%b done=%b err=%b", start_ready, busy, done, err);
        end
        total++;
        if (lane_valid !== '0 || lane_index !== '0) begin
            bad++;
            $display("FAIL reset_lanes: valid=%b index=%h required 0", lane_valid, lane_index);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_u0_sparse();
        logic [MASK_WIDTH-1:0] m;
        int cyc;
        m = '0;
        m[0] = 1'b1; m[63] = 1'b1; m[64] = 1'b1; m[255] = 1'b1;
        accept(m, 0);
        drain(0, 1'b0, 1'b0, cyc);
        total++;
        if (cyc !== 3) begin
            bad++;
            $display("FAIL u0_latency: cycles=%0d required=3", cyc);
        end
    endtask

    task automatic test_u1_mapping();
        logic [MASK_WIDTH-1:0] m;
        int cyc;
        m = '0;
        m[144] = 1'b1;
        accept(m, 1);
        total++;
        if (lane_valid !== 4'b1000 || lane_index[3*IDX_W +: IDX_W] !== 8'd144) begin
            bad++;
            $display("FAIL u1_144: valid=%b idx3=%0d required 1000/144", lane_valid,
                     lane_index[3*IDX_W +: IDX_W]);
        end
        drain(0, 1'b0, 1'b0, cyc);
        m = '0;
        m[40] = 1'b1;
        accept(m, 1);
        total++;
        if (lane_valid !== 4'b0001 || lane_index[0 +: IDX_W] !== 8'd40) begin
            bad++;
            $display("FAIL u1_40: valid=%b idx0=%0d required 0001/40", lane_valid, lane_index[0 +: IDX_W]);
        end
        drain(0, 1'b0, 1'b0, cyc);
    endtask

    task automatic test_u2_stall();
        int cyc;
        accept('1, 2);
        total++;
        if (lane_index[1*IDX_W +: IDX_W] !== 8'd8) begin
            bad++;
            $display("FAIL u2_first: idx1=%0d required=8", lane_index[1*IDX_W +: IDX_W]);
        end
        drain(5, 1'b0, 1'b0, cyc);
    endtask

    task automatic test_zero_and_invalid();
        int cyc;
        accept('0, 0);
        drain(0, 1'b0, 1'b0, cyc);
        total++;
        if (cyc !== 1) begin
            bad++;
            $display("FAIL zero_latency: cycles=%0d required=1", cyc);
        end
        accept({8{32'hdead_beef}}, 3);
        drain(0, 1'b0, 1'b1, cyc);
        total++;
        if (cyc !== 1) begin
            bad++;
            $display("FAIL invalid_latency: cycles=%0d required=1", cyc);
        end
    endtask

    task automatic test_reset_mid();
        logic [MASK_WIDTH-1:0] m;
        int cyc;
        accept('1, 0);
        lane_ready = '1;
        repeat (3) step();
        lane_ready = '0;
        rst_n = 1'b0;
        step();
        total++;
        if (lane_valid !== '0 || busy !== 1'b0 || start_ready !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: valid=%b busy=%b ready=%b done=%b", lane_valid, busy,
                     start_ready, done);
        end
        rst_n = 1'b1;
        step();
        total++;
        if (done !== 1'b0 || start_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_after: done=%b ready=%b required 0/1", done, start_ready);
        end
        m = '0;
        m[5] = 1'b1; m[70] = 1'b1; m[200] = 1'b1;
        accept(m, 0);
        drain(0, 1'b0, 1'b0, cyc);
    endtask

    task automatic test_random();
        logic [MASK_WIDTH-1:0] m;
        int cyc;
        for (int i = 0; i < 6; i++) begin
            for (int w = 0; w < MASK_WIDTH / 32; w++) begin
                m[w*32 +: 32] = $urandom() & $urandom();
            end
            accept(m, $urandom_range(0, 2));
            drain(0, 1'b1, 1'b0, cyc);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        start_valid  = 1'b0;
        start_mask   = '0;
        start_unroll = '0;
        lane_ready   = '0;
        #1;
        test_reset();
        test_u0_sparse();
        test_u1_mapping();
        test_u2_stall();
        test_zero_and_invalid();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
